// File: rtl/user_wb_pkg.sv
// Shared types and constants for the user-area Wishbone bridge:
// FSM encoding, slave indices, default address bases and the error-response word.
package user_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int NUM_SLV   = 3;
  localparam int FIR_IDX   = 0;
  localparam int MM_IDX    = 1;
  localparam int SDRAM_IDX = 2;

  localparam logic [11:0] FIR_BASE_DEF   = 12'h320;
  localparam logic [11:0] MM_BASE_DEF    = 12'h340;
  localparam logic [11:0] SDRAM_BASE_DEF = 12'h380;
  localparam logic [31:0] ERR_DATA_DEF   = 32'hDEAD_BEEF;

  // Pick the 32-bit read-data lane of the one-hot selected slave.
  function automatic logic [31:0] slv_slice(input logic [95:0] dat, input logic [2:0] oh);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (oh[i]) res = res | dat[i*32 +: 32];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_wb_watchdog.sv
// Per-transaction cycle counter: clear/load/enable, flags terminal count at TIMEOUT-1.
// Single-cycle update; no handshake, the owner decides when it runs.
module user_wb_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/user_wb_bridge.sv
// Registered Wishbone bridge to FIR/MM/SDRAM slaves, one transaction in flight, timeout watchdog.
// Latency >= 2 cycles mapped, 1 unmapped; a silent slave is aborted after TIMEOUT cycles with ERR_DATA.
module user_wb_bridge
  import user_wb_pkg::*;
#(
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF,
  parameter logic [11:0] FIR_BASE   = FIR_BASE_DEF,
  parameter logic [11:0] MM_BASE    = MM_BASE_DEF,
  parameter logic [11:0] SDRAM_BASE = SDRAM_BASE_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  s_cyc_o,
  output logic [2:0]  s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [2:0]  s_ack_i,
  input  logic [95:0] s_dat_i,
  output logic        err_irq_o,
  output logic [15:0] err_cnt_o
);

  state_t      state, state_nxt;
  logic [2:0]  tgt_q, tgt_nxt, hit, stb_nxt;
  logic [31:0] dat_nxt;
  logic        req, slv_ack, wd_tc, latch, err_nxt, ack_nxt;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign slv_ack = |(s_ack_i & tgt_q);

  always_comb begin
    hit            = '0;
    hit[FIR_IDX]   = (wbs_adr_i[31:20] == FIR_BASE);
    hit[MM_IDX]    = (wbs_adr_i[31:20] == MM_BASE);
    hit[SDRAM_IDX] = (wbs_adr_i[31:20] == SDRAM_BASE);
  end

  user_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clr    (latch),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (state == ST_FWD),
    .tc     (wd_tc)
  );

  // State and all output registers; nothing reaches a port combinationally.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state     <= ST_IDLE;
      tgt_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      s_cyc_o   <= '0;
      s_stb_o   <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      err_irq_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      tgt_q     <= tgt_nxt;
      wbs_ack_o <= ack_nxt;
      wbs_dat_o <= dat_nxt;
      s_cyc_o   <= stb_nxt;
      s_stb_o   <= stb_nxt;
      err_irq_o <= err_nxt;
      if (err_nxt && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
      if (latch) begin
        s_we_o  <= wbs_we_i;
        s_sel_o <= wbs_sel_i;
        s_adr_o <= wbs_adr_i;
        s_dat_o <= wbs_dat_i;
      end
    end
  end

  // Master abort takes priority; a slave ack beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (|hit) ? ST_FWD : ST_RESP;
      ST_FWD: begin
        if (!wbs_cyc_i)             state_nxt = ST_IDLE;
        else if (slv_ack || wd_tc)  state_nxt = ST_RESP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    latch   = 1'b0;
    tgt_nxt = tgt_q;
    err_nxt = 1'b0;
    dat_nxt = wbs_dat_o;
    case (state)
      ST_IDLE: begin
        if (req) begin
          latch   = 1'b1;
          tgt_nxt = hit;
          if (!(|hit)) begin
            err_nxt = 1'b1;
            dat_nxt = ERR_DATA;
          end
        end
      end
      ST_FWD: begin
        if (wbs_cyc_i) begin
          if (slv_ack) begin
            dat_nxt = s_we_o ? 32'h0 : slv_slice(s_dat_i, tgt_q);
          end else if (wd_tc) begin
            err_nxt = 1'b1;
            dat_nxt = ERR_DATA;
          end
        end
      end
      default: ;
    endcase
    ack_nxt = (state_nxt == ST_RESP);
    stb_nxt = (state_nxt == ST_FWD) ? tgt_nxt : 3'b000;
  end

endmodule

// File: tb/tb_user_wb_bridge.sv
// Self-checking bench for user_wb_bridge: directed scenarios plus randomized accesses
// checked against a transaction-level model of latency, data and error accounting.
module tb_user_wb_bridge;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
  localparam int          NEVER   = 1000;

  logic        wb_clk_i, wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [2:0]  s_cyc_o, s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [2:0]  s_ack_i;
  logic [95:0] s_dat_i;
  logic        err_irq_o;
  logic [15:0] err_cnt_o;

  int checks = 0;
  int errors = 0;
  int err_model = 0;

  // Observations from the last run_txn call.
  int          o_lat, o_stb, o_bad, o_fld, o_irq;
  logic [31:0] o_dat;
  // Expectations from predict.
  int          e_lat, e_stb, e_err;
  logic [31:0] e_dat;

  user_wb_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_cyc_o  (s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o  (s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .err_irq_o(err_irq_o), .err_cnt_o(err_cnt_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within the time bound");
    $fatal(1);
  end

  function automatic int tgt_of(input logic [31:0] adr);
    case (adr[31:20])
      12'h320: return 0;
      12'h340: return 1;
      12'h380: return 2;
      default: return -1;
    endcase
  endfunction

  // Transaction-level outcome: cycles to master ack, data, strobe cycles, error flag.
  task automatic predict(input int t, input int ack_at, input logic we, input logic [31:0] rdat);
    if (t < 0) begin
      e_lat = 1; e_dat = ERR; e_stb = 0; e_err = 1;
    end else if (ack_at <= TIMEOUT) begin
      e_lat = ack_at + 1; e_dat = we ? 32'h0 : rdat; e_stb = ack_at; e_err = 0;
    end else begin
      e_lat = TIMEOUT + 1; e_dat = ERR; e_stb = TIMEOUT; e_err = 1;
    end
  endtask

  // Drives one master request and a slave that acks during cycle ack_at; cycle n is the one after the n-th edge.
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                         input logic noise);
    int t;
    logic [2:0] tmask;
    t = tgt_of(adr);
    tmask = (t >= 0) ? (3'b001 << t) : 3'b000;
    o_lat = -1; o_stb = 0; o_bad = 0; o_fld = 0; o_irq = 0; o_dat = 'x;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = wdat; s_ack_i = 3'b000;
    for (int n = 1; n <= 200; n++) begin
      @(negedge wb_clk_i);
      if (s_stb_o != 3'b000) begin
        o_stb++;
        if (s_stb_o !== tmask || s_cyc_o !== s_stb_o) o_bad++;
        if (s_adr_o !== adr || s_dat_o !== wdat || s_we_o !== we || s_sel_o !== sel) o_fld++;
      end
      if (err_irq_o) o_irq++;
      if (wbs_ack_o) begin
        o_lat = n; o_dat = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; s_ack_i = 3'b000;
        break;
      end
      s_dat_i = {$urandom, $urandom, $urandom};
      if (t >= 0) s_dat_i[t*32 +: 32] = rdat;
      s_ack_i = noise ? (3'($urandom) & ~tmask) : 3'b000;
      if (n == ack_at) s_ack_i = s_ack_i | tmask;
    end
    if (o_lat < 0) begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; s_ack_i = 3'b000;
    end
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3200_0000; wbs_dat_i = 32'h1111_2222; s_ack_i = 3'b000; s_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if ({wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_irq_o, err_cnt_o} !== 125'h0) begin
      errors++; $display("FAIL reset_outputs: got ack=%b stb=%b adr=%h cnt=%0d, expected all zero", wbs_ack_o, s_stb_o, s_adr_o, err_cnt_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wb_rst_i = 1'b1;
  endtask

  task automatic test_fir_read;
    @(negedge wb_clk_i);
    run_txn(32'h3200_0010, 32'h0, 1'b0, 4'hF, 3, 32'h1234_5678, 1'b0);
    checks++; if (o_lat !== 4) begin errors++; $display("FAIL fir_latency: got %0d, expected 4", o_lat); end
    checks++; if (o_dat !== 32'h1234_5678) begin errors++; $display("FAIL fir_data: got %h, expected 12345678", o_dat); end
    checks++; if (o_bad !== 0 || o_stb !== 3) begin errors++; $display("FAIL fir_strobe: bad=%0d cycles=%0d, expected 0 and 3", o_bad, o_stb); end
    checks++; if (err_cnt_o !== 16'd0) begin errors++; $display("FAIL fir_errcnt: got %0d, expected 0", err_cnt_o); end
  endtask

  task automatic test_sdram_write;
    @(negedge wb_clk_i);
    run_txn(32'h3800_0000, 32'hA5A5_A5A5, 1'b1, 4'b0011, 2, $urandom, 1'b0);
    checks++; if (o_fld !== 0) begin errors++; $display("FAIL wr_fields: %0d cycles with wrong s_adr/s_dat/s_sel/s_we", o_fld); end
    checks++; if (o_bad !== 0 || o_stb !== 2) begin errors++; $display("FAIL wr_strobe: bad=%0d cycles=%0d, expected 0 and 2", o_bad, o_stb); end
    checks++; if (o_lat !== 3 || o_dat !== 32'h0) begin errors++; $display("FAIL wr_ack: lat=%0d dat=%h, expected 3 and 0", o_lat, o_dat); end
    checks++; if (o_irq !== 0) begin errors++; $display("FAIL wr_irq: got %0d pulses, expected 0", o_irq); end
    @(negedge wb_clk_i);
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL wr_single_ack: ack still %b after response, expected 0", wbs_ack_o); end
  endtask

  task automatic test_unmapped;
    @(negedge wb_clk_i);
    run_txn(32'h3000_0000, 32'h0, 1'b0, 4'hF, 1, 32'h5555_5555, 1'b0);
    err_model++;
    checks++; if (o_lat !== 1 || o_dat !== ERR) begin errors++; $display("FAIL unmapped_ack: lat=%0d dat=%h, expected 1 and deadbeef", o_lat, o_dat); end
    checks++; if (o_stb !== 0) begin errors++; $display("FAIL unmapped_strobe: got %0d strobe cycles, expected 0", o_stb); end
    checks++; if (o_irq !== 1) begin errors++; $display("FAIL unmapped_irq: got %0d pulses, expected 1", o_irq); end
    checks++; if (err_cnt_o !== 16'(err_model)) begin errors++; $display("FAIL unmapped_errcnt: got %0d, expected %0d", err_cnt_o, err_model); end
  endtask

  task automatic test_timeout;
    @(negedge wb_clk_i);
    run_txn(32'h3400_0004, 32'h0, 1'b0, 4'hF, NEVER, 32'h0, 1'b0);
    err_model++;
    checks++; if (o_stb !== TIMEOUT || o_bad !== 0) begin errors++; $display("FAIL tmo_strobe: cycles=%0d bad=%0d, expected %0d and 0", o_stb, o_bad, TIMEOUT); end
    checks++; if (o_lat !== TIMEOUT + 1 || o_dat !== ERR) begin errors++; $display("FAIL tmo_ack: lat=%0d dat=%h, expected %0d and deadbeef", o_lat, o_dat, TIMEOUT + 1); end
    checks++; if (o_irq !== 1 || err_cnt_o !== 16'(err_model)) begin errors++; $display("FAIL tmo_err: irq=%0d cnt=%0d, expected 1 and %0d", o_irq, err_cnt_o, err_model); end
  endtask

  task automatic test_timeout_edge_ack;
    @(negedge wb_clk_i);
    run_txn(32'h3400_0008, 32'h0, 1'b0, 4'hF, TIMEOUT, 32'hCAFE_F00D, 1'b0);
    checks++; if (o_lat !== TIMEOUT + 1 || o_dat !== 32'hCAFE_F00D) begin errors++; $display("FAIL edge_ack: lat=%0d dat=%h, expected %0d and cafef00d", o_lat, o_dat, TIMEOUT + 1); end
    checks++; if (o_irq !== 0 || err_cnt_o !== 16'(err_model)) begin errors++; $display("FAIL edge_err: irq=%0d cnt=%0d, expected 0 and %0d", o_irq, err_cnt_o, err_model); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    @(negedge wb_clk_i);
    run_txn(32'h3200_0100, 32'h0, 1'b0, 4'hF, 1, 32'h0BAD_CAFE, 1'b0);
    checks++; if (o_lat !== 2 || o_dat !== 32'h0BAD_CAFE) begin errors++; $display("FAIL b2b_first: lat=%0d dat=%h, expected 2 and 0badcafe", o_lat, o_dat); end
    // No idle gap: the second request is already present while the bridge sits in RESP.
    d = $urandom;
    run_txn(32'h3800_0040, 32'h0, 1'b0, 4'hF, 3, d, 1'b0);
    checks++; if (o_lat !== 4 || o_dat !== d) begin errors++; $display("FAIL b2b_second: lat=%0d dat=%h, expected 4 and %h", o_lat, o_dat, d); end
    checks++; if (o_stb !== 2 || o_bad !== 0) begin errors++; $display("FAIL b2b_strobe: cycles=%0d bad=%0d, expected 2 and 0", o_stb, o_bad); end
  endtask

  task automatic test_abort;
    int acks, irqs;
    acks = 0; irqs = 0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3400_0100;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (s_stb_o !== 3'b010) begin errors++; $display("FAIL abort_pre: s_stb_o=%b, expected 010", s_stb_o); end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    checks++; if ({s_cyc_o, s_stb_o} !== 6'b0) begin errors++; $display("FAIL abort_strobe: cyc=%b stb=%b, expected 000", s_cyc_o, s_stb_o); end
    s_ack_i = 3'b010;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
      if (err_irq_o) irqs++;
      s_ack_i = 3'b000;
    end
    checks++; if (acks !== 0 || irqs !== 0) begin errors++; $display("FAIL abort_ack: acks=%0d irqs=%0d, expected 0 and 0", acks, irqs); end
    checks++; if (err_cnt_o !== 16'(err_model)) begin errors++; $display("FAIL abort_errcnt: got %0d, expected %0d", err_cnt_o, err_model); end
    run_txn(32'h3400_0200, 32'h0, 1'b0, 4'hF, 1, 32'h7777_0001, 1'b0);
    checks++; if (o_lat !== 2 || o_dat !== 32'h7777_0001) begin errors++; $display("FAIL abort_after: lat=%0d dat=%h, expected 2 and 77770001", o_lat, o_dat); end
  endtask

  task automatic test_random;
    logic [31:0] adr, wdat, rdat;
    logic        we;
    logic [3:0]  sel;
    int          kind, ack_at;
    logic [11:0] bases [3];
    bases[0] = 12'h320; bases[1] = 12'h340; bases[2] = 12'h380;
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 3);
      adr  = $urandom;
      if (kind < 3) adr[31:20] = bases[kind];
      wdat = $urandom; rdat = $urandom; we = 1'($urandom); sel = 4'($urandom);
      ack_at = $urandom_range(1, 72);
      predict(tgt_of(adr), ack_at, we, rdat);
      @(negedge wb_clk_i);
      run_txn(adr, wdat, we, sel, ack_at, rdat, 1'b1);
      err_model += e_err;
      checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d, expected %0d (adr=%h ack_at=%0d)", it, o_lat, e_lat, adr, ack_at); end
      checks++; if (o_dat !== e_dat) begin errors++; $display("FAIL rnd%0d_data: got %h, expected %h", it, o_dat, e_dat); end
      checks++; if (o_stb !== e_stb || o_bad !== 0) begin errors++; $display("FAIL rnd%0d_strobe: cycles=%0d bad=%0d, expected %0d and 0", it, o_stb, o_bad, e_stb); end
      checks++; if (o_fld !== 0) begin errors++; $display("FAIL rnd%0d_fields: %0d cycles with wrong slave-side copy", it, o_fld); end
      checks++; if (o_irq !== e_err) begin errors++; $display("FAIL rnd%0d_irq: got %0d pulses, expected %0d", it, o_irq, e_err); end
      checks++; if (err_cnt_o !== 16'(err_model)) begin errors++; $display("FAIL rnd%0d_errcnt: got %0d, expected %0d", it, err_cnt_o, err_model); end
    end
  endtask

  task automatic test_reset_mid_fwd;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hC;
    wbs_adr_i = 32'h3200_0ABC; wbs_dat_i = 32'h8765_4321; s_ack_i = 3'b000;
    repeat (5) @(negedge wb_clk_i);
    checks++; if (s_stb_o !== 3'b001) begin errors++; $display("FAIL rstfwd_pre: s_stb_o=%b, expected 001", s_stb_o); end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if ({wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_irq_o, err_cnt_o} !== 125'h0) begin
      errors++; $display("FAIL rstfwd_outputs: stb=%b adr=%h dat=%h cnt=%0d, expected all zero", s_stb_o, s_adr_o, s_dat_o, err_cnt_o);
    end
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; err_model = 0;
    @(negedge wb_clk_i);
    run_txn(32'h3200_0010, 32'h0, 1'b0, 4'hF, 2, 32'h2468_ACE0, 1'b0);
    checks++; if (o_lat !== 3 || o_dat !== 32'h2468_ACE0) begin errors++; $display("FAIL rstfwd_after: lat=%0d dat=%h, expected 3 and 2468ace0", o_lat, o_dat); end
    checks++; if (err_cnt_o !== 16'd0 || o_bad !== 0) begin errors++; $display("FAIL rstfwd_clean: cnt=%0d bad=%0d, expected 0 and 0", err_cnt_o, o_bad); end
  endtask

  initial begin
    test_reset();
    test_fir_read();
    test_sdram_write();
    test_unmapped();
    test_timeout();
    test_timeout_edge_ack();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid_fwd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
